// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: RV32I opcode constants,
// ALU operation codes, the issue packet and the issue-stage state encoding.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    typedef struct packed {
        logic [31:0] operand_1;
        logic [31:0] operand_2;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic        reg_write;
        logic        illegal;
    } issue_pkt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } issue_state_e;

    // Sign-extend a 12-bit I-type immediate to 32 bits.
    function automatic logic [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I ALU-instruction decoder: turns a raw instruction word
// plus register/pc data into an issue packet. Unsupported encodings produce
// an all-zero packet with only the illegal flag set.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output issue_pkt_t  pkt
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rd_s;
    logic        legal_s;
    logic [3:0]  alu_op_s;
    logic [31:0] op1_s;
    logic [31:0] op2_s;
    logic        unused_rs1_idx_s;

    assign opcode_s = instruction[6:0];
    assign rd_s     = instruction[11:7];
    assign funct3_s = instruction[14:12];
    assign funct7_s = instruction[31:25];

    // The rs1 index is resolved by the register file upstream; only its data is used here.
    assign unused_rs1_idx_s = ^instruction[19:15];

    // Decode opcode/funct fields into operation, operands and legality.
    always_comb begin
        legal_s  = 1'b1;
        alu_op_s = ALU_ADD;
        op1_s    = rs1_data;
        op2_s    = rs2_data;
        case (opcode_s)
            OPC_OP: begin
                if (funct7_s == F7_BASE) begin
                    case (funct3_s)
                        3'b000:  alu_op_s = ALU_ADD;
                        3'b001:  alu_op_s = ALU_SLL;
                        3'b010:  alu_op_s = ALU_SLT;
                        3'b011:  alu_op_s = ALU_SLTU;
                        3'b100:  alu_op_s = ALU_XOR;
                        3'b101:  alu_op_s = ALU_SRL;
                        3'b110:  alu_op_s = ALU_OR;
                        3'b111:  alu_op_s = ALU_AND;
                        default: legal_s  = 1'b0;
                    endcase
                end else if (funct7_s == F7_ALT) begin
                    case (funct3_s)
                        3'b000:  alu_op_s = ALU_SUB;
                        3'b101:  alu_op_s = ALU_SRA;
                        default: legal_s  = 1'b0;
                    endcase
                end else begin
                    legal_s = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                op2_s = sext12(instruction[31:20]);
                case (funct3_s)
                    3'b000: alu_op_s = ALU_ADD;
                    3'b010: alu_op_s = ALU_SLT;
                    3'b011: alu_op_s = ALU_SLTU;
                    3'b100: alu_op_s = ALU_XOR;
                    3'b110: alu_op_s = ALU_OR;
                    3'b111: alu_op_s = ALU_AND;
                    3'b001: begin
                        op2_s    = {27'd0, instruction[24:20]};
                        alu_op_s = ALU_SLL;
                        if (funct7_s == F7_BASE) begin
                            legal_s = 1'b1;
                        end else begin
                            legal_s = 1'b0;
                        end
                    end
                    3'b101: begin
                        op2_s = {27'd0, instruction[24:20]};
                        if (funct7_s == F7_BASE) begin
                            alu_op_s = ALU_SRL;
                        end else if (funct7_s == F7_ALT) begin
                            alu_op_s = ALU_SRA;
                        end else begin
                            legal_s = 1'b0;
                        end
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OPC_LUI: begin
                op1_s = 32'd0;
                op2_s = {instruction[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                op1_s = pc;
                op2_s = {instruction[31:12], 12'd0};
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Assemble the packet; illegal encodings are scrubbed to zero apart from the flag.
    always_comb begin
        pkt = '0;
        if (legal_s) begin
            pkt.operand_1 = op1_s;
            pkt.operand_2 = op2_s;
            pkt.alu_op    = alu_op_s;
            pkt.rd        = rd_s;
            pkt.reg_write = (rd_s != 5'd0);
            pkt.illegal   = 1'b0;
        end else begin
            pkt.illegal   = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one RV32I instruction per cycle into a registered
// issue packet with valid/ready handshakes on both sides.
// Build option ALU_ISSUE_SKID_EN: adds a skid register and SKID state so that
// in_ready is a flop output while keeping full throughput under back-pressure.
// Without it, in_ready = !out_valid || out_ready combinationally.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] operand_1,
    output logic [XLEN-1:0] operand_2,
    output logic [3:0]      aluOperation,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            illegal
);

    issue_state_e state_q, state_d;
    issue_pkt_t   out_pkt_q, out_pkt_d;
    issue_pkt_t   dec_pkt_s;
    logic         out_valid_q, out_valid_d;
    logic         accept_s;
    logic         issue_s;

`ifdef ALU_ISSUE_SKID_EN
    issue_pkt_t   skid_pkt_q, skid_pkt_d;
    logic         in_ready_q, in_ready_d;
    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid_q || out_ready;
`endif

    alu_op_decode u_decode (
        .instruction (instruction),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .pkt         (dec_pkt_s)
    );

    assign accept_s = in_valid && in_ready;
    assign issue_s  = out_valid_q && out_ready;

    // Next-state and register-load logic; flush overrides any handshake.
    always_comb begin
        state_d   = state_q;
        out_pkt_d = out_pkt_q;
`ifdef ALU_ISSUE_SKID_EN
        skid_pkt_d = skid_pkt_q;
`endif
        if (flush) begin
            state_d   = ST_EMPTY;
            out_pkt_d = '0;
`ifdef ALU_ISSUE_SKID_EN
            skid_pkt_d = '0;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d   = ST_FULL;
                        out_pkt_d = dec_pkt_s;
                    end else begin
                        state_d   = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_s && issue_s) begin
                        out_pkt_d = dec_pkt_s;
                    end else if (accept_s) begin
`ifdef ALU_ISSUE_SKID_EN
                        state_d    = ST_SKID;
                        skid_pkt_d = dec_pkt_s;
`else
                        out_pkt_d  = dec_pkt_s;
`endif
                    end else if (issue_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_SKID: begin
`ifdef ALU_ISSUE_SKID_EN
                    if (issue_s) begin
                        state_d   = ST_FULL;
                        out_pkt_d = skid_pkt_q;
                    end else begin
                        state_d   = ST_SKID;
                    end
`else
                    state_d = ST_EMPTY;
`endif
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
`ifdef ALU_ISSUE_SKID_EN
        in_ready_d  = (state_d != ST_SKID);
`endif
    end

    // State and packet registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_pkt_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_ISSUE_SKID_EN
            skid_pkt_q  <= '0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            out_pkt_q   <= out_pkt_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_ISSUE_SKID_EN
            skid_pkt_q  <= skid_pkt_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    assign out_valid    = out_valid_q;
    assign operand_1    = out_pkt_q.operand_1;
    assign operand_2    = out_pkt_q.operand_2;
    assign aluOperation = out_pkt_q.alu_op;
    assign rd           = out_pkt_q.rd;
    assign reg_write    = out_pkt_q.reg_write;
    assign illegal      = out_pkt_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage with hand-written
// sequences for back-pressure, flush and mid-stream reset.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic [3:0]  aluOperation;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  aop;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    alu_issue_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .pc           (pc),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .operand_1    (operand_1),
        .operand_2    (operand_2),
        .aluOperation (aluOperation),
        .rd           (rd),
        .reg_write    (reg_write),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid    = v;
        instruction = ins;
        pc          = p;
        rs1_data    = a;
        rs2_data    = b;
    endtask

    int          idx;
    int          acc_stall;
    logic        acc;
    logic        iss;
    logic [31:0] tag;
    int          iss_tag[$];
    int          iss_cyc[$];

    initial begin
        //            instr          pc          rs1           rs2           op1           op2           aop    rd     rw    ill
        vecs[0]  = '{32'h002081B3, 32'h0,     32'd5,        32'd7,        32'd5,        32'd7,        4'h0, 5'd3,  1'b1, 1'b0}; // ADD x3
        vecs[1]  = '{32'h4030D213, 32'h0,     32'h80000000, 32'd9,        32'h80000000, 32'd3,        4'h5, 5'd4,  1'b1, 1'b0}; // SRAI x4,x1,3
        vecs[2]  = '{32'hFFF00293, 32'h0,     32'd0,        32'd9,        32'd0,        32'hFFFFFFFF, 4'h0, 5'd5,  1'b1, 1'b0}; // ADDI x5,x0,-1
        vecs[3]  = '{32'h12345317, 32'h100,   32'hAA,       32'hBB,       32'h100,      32'h12345000, 4'h0, 5'd6,  1'b1, 1'b0}; // AUIPC
        vecs[4]  = '{32'h123453B7, 32'h104,   32'hAA,       32'hBB,       32'd0,        32'h12345000, 4'h0, 5'd7,  1'b1, 1'b0}; // LUI
        vecs[5]  = '{32'h00002403, 32'h108,   32'hAA,       32'hBB,       32'd0,        32'd0,        4'h0, 5'd0,  1'b0, 1'b1}; // load opcode
        vecs[6]  = '{32'h022084B3, 32'h10C,   32'hAA,       32'hBB,       32'd0,        32'd0,        4'h0, 5'd0,  1'b0, 1'b1}; // funct7 0000001
        vecs[7]  = '{32'h40208533, 32'h0,     32'd10,       32'd3,        32'd10,       32'd3,        4'h1, 5'd10, 1'b1, 1'b0}; // SUB
        vecs[8]  = '{32'h0020B5B3, 32'h0,     32'd1,        32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'h4, 5'd11, 1'b1, 1'b0}; // SLTU
        vecs[9]  = '{32'h7FF0C613, 32'h0,     32'h1234,     32'h55,       32'h1234,     32'h7FF,      4'h7, 5'd12, 1'b1, 1'b0}; // XORI 0x7FF
        vecs[10] = '{32'h00208033, 32'h0,     32'd1,        32'd2,        32'd1,        32'd2,        4'h0, 5'd0,  1'b0, 1'b0}; // ADD x0
        vecs[11] = '{32'h8000F693, 32'h0,     32'hFF,       32'h55,       32'hFF,       32'hFFFFF800, 4'h9, 5'd13, 1'b1, 1'b0}; // ANDI -2048
        vecs[12] = '{32'h40309713, 32'h0,     32'hFF,       32'h55,       32'd0,        32'd0,        4'h0, 5'd0,  1'b0, 1'b1}; // SLLI bad funct7
        vecs[13] = '{32'h0020D7B3, 32'h0,     32'h80,       32'd4,        32'h80,       32'd4,        4'h6, 5'd15, 1'b1, 1'b0}; // SRL
        vecs[14] = '{32'h0020E833, 32'h0,     32'h0F,       32'hF0,       32'h0F,       32'hF0,       4'h8, 5'd16, 1'b1, 1'b0}; // OR
        vecs[15] = '{32'h002098B3, 32'h0,     32'd1,        32'd31,       32'd1,        32'd31,       4'h2, 5'd17, 1'b1, 1'b0}; // SLL
        vecs[16] = '{32'hFFB0A913, 32'h0,     32'd3,        32'h55,       32'd3,        32'hFFFFFFFB, 4'h3, 5'd18, 1'b1, 1'b0}; // SLTI -5
        vecs[17] = '{32'h4020D9B3, 32'h0,     32'h80000000, 32'd1,        32'h80000000, 32'd1,        4'h5, 5'd19, 1'b1, 1'b0}; // SRA

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op1", operand_1, 32'd0);
        chk("rst_op2", operand_2, 32'd0);
        chk("rst_aop", 32'(aluOperation), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_rw", 32'(reg_write), 32'd0);
        chk("rst_ill", 32'(illegal), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Streaming table: one instruction per cycle, result one cycle later.
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_op1", i), operand_1, vecs[i].op1);
            chk($sformatf("v%0d_op2", i), operand_2, vecs[i].op2);
            chk($sformatf("v%0d_aop", i), 32'(aluOperation), 32'(vecs[i].aop));
            chk($sformatf("v%0d_rw", i), 32'(reg_write), 32'(vecs[i].rw));
            chk($sformatf("v%0d_ill", i), 32'(illegal), 32'(vecs[i].ill));
            if (!vecs[i].ill) begin
                chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
            end
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Back-pressure: three back-to-back ADDs tagged by rs1 data 1,2,3.
        idx = 0;
        acc_stall = 0;
        for (int c = 0; c < 9; c++) begin
            out_ready = (c >= 3);
            drive(idx < 3, 32'h00208033 | (32'(idx + 3) << 7), 32'd0, 32'(idx + 1), 32'd0);
            #5;
            acc = in_valid && in_ready;
            iss = out_valid && out_ready;
            tag = operand_1;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (c < 3) acc_stall++;
            end
            if (iss) begin
                iss_tag.push_back(int'(tag));
                iss_cyc.push_back(c);
            end
            if (c < 3) begin
                chk($sformatf("bp_hold_op1_c%0d", c), operand_1, 32'd1);
                chk($sformatf("bp_hold_rd_c%0d", c), 32'(rd), 32'd3);
                chk($sformatf("bp_hold_valid_c%0d", c), 32'(out_valid), 32'd1);
            end
            if (c == 2) begin
                chk("bp_in_ready_stalled", 32'(in_ready), 32'd0);
            end
        end
`ifdef ALU_ISSUE_SKID_EN
        chk("bp_accepted_in_stall", 32'(acc_stall), 32'd2);
`else
        chk("bp_accepted_in_stall", 32'(acc_stall), 32'd1);
`endif
        chk("bp_issue_count", 32'(iss_tag.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < iss_tag.size()) begin
                chk($sformatf("bp_issue_tag%0d", k), 32'(iss_tag[k]), 32'(k + 1));
                chk($sformatf("bp_issue_cycle%0d", k), 32'(iss_cyc[k]), 32'(k + 3));
            end
        end
        chk("bp_final_out_valid", 32'(out_valid), 32'd0);

        // Flush with a same-cycle incoming instruction.
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd0, 32'h11, 32'd0);
        tick();
`ifdef ALU_ISSUE_SKID_EN
        drive(1'b1, 32'h002081B3, 32'd0, 32'h22, 32'd0);
        tick();
        chk("fl_pre_in_ready", 32'(in_ready), 32'd0);
`endif
        chk("fl_pre_out_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h002081B3, 32'd0, 32'h33, 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl_no_issue%0d", k), 32'(out_valid), 32'd0);
        end

        // Reset in the middle of a stalled stream, with flush also raised.
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd0, 32'h44, 32'd0);
        tick();
        chk("mr_pre_out_valid", 32'(out_valid), 32'd1);
        drive(1'b1, 32'h002081B3, 32'd0, 32'h55, 32'd0);
        tick();
        rst = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h002081B3, 32'd0, 32'h66, 32'd0);
        tick();
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_op1", operand_1, 32'd0);
        chk("mr_aop", 32'(aluOperation), 32'd0);
        chk("mr_rw", 32'(reg_write), 32'd0);
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        chk("mr_post_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decode-side instruction valid
- in_ready  out  1  stage can accept an instruction
- instruction  in  32  raw RV32I instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register-file read data for rs1
- rs2_data  in  32  register-file read data for rs2
- flush  in  1  discard all held and incoming entries
- out_valid  out  1  issue packet valid
- out_ready  in  1  ALU/execute side accepts the packet
- operand_1  out  32  ALU first operand
- operand_2  out  32  ALU second operand
- aluOperation  out  4  ALU operation code
- rd  out  5  destination register
- reg_write  out  1  result is written back
- illegal  out  1  instruction is not a supported ALU instruction
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL transfer on in_valid&&in_ready (accept) and on out_valid&&out_ready (issue).
REQ-005 SHALL encode aluOperation as: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 SRA, 0110 SRL, 0111 XOR, 1000 OR, 1001 AND.
REQ-006 SHALL decode opcode 0110011 (R-type): operand_1=rs1_data, operand_2=rs2_data; op from funct3, with funct7=0100000 selecting SUB (funct3 000) or SRA (funct3 101); all other funct7 values other than 0000000 are illegal.
REQ-007 SHALL decode opcode 0010011 (I-type): operand_2=sign-extended imm[11:0]; SLLI/SRLI/SRAI use operand_2={27'b0,instr[24:20]}; SRAI when instr[31:25]=0100000; other shift funct7 values are illegal.
REQ-008 SHALL decode LUI (0110111) as ADD with operand_1=0, operand_2={instr[31:12],12'b0}, and AUIPC (0010111) as ADD with operand_1=pc and the same operand_2.
REQ-009 SHALL, for any other opcode or illegal encoding, set illegal=1, reg_write=0, aluOperation=0000, operand_1/operand_2=0; illegal packets are still issued.
REQ-010 SHALL set reg_write=1 for legal instructions with rd!=0, and reg_write=0 when rd=0.
REQ-011 SHALL have one-cycle latency: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1.
REQ-012 SHALL hold all output fields stable while out_valid=1 and out_ready=0.
REQ-013 SHALL keep the state machine EMPTY (no packet), FULL (output register valid), SKID (output and skid register valid).
- EMPTY to FULL on accept.
- FULL to EMPTY on issue without accept.
- FULL to SKID on accept without issue.
- SKID to FULL on issue; the skid entry moves to the output register.
REQ-014 SHALL drive in_ready=1 in EMPTY and FULL and in_ready=0 in SKID; in_ready SHALL be a register output.
REQ-015 SHALL, in FULL with simultaneous accept and issue, load the new packet into the output register and remain in FULL.
REQ-016 SHALL, on flush, go to EMPTY next cycle, dropping held entries and any same-cycle accept; flush SHALL take priority over accept and issue.
REQ-017 SHALL preserve issue order; no packet is duplicated or lost except by flush or reset.

Reset
REQ-018 SHALL, on rst, enter EMPTY and drive out_valid=0, in_ready=1 next cycle, and drive operand_1, operand_2, aluOperation, rd, reg_write and illegal to 0.
REQ-019 SHALL, on rst asserted mid-operation, discard all entries; rst SHALL take priority over flush.

Configuration
REQ-020 SHALL, with ALU_ISSUE_SKID_EN defined, implement REQ-013 to REQ-015 (registered in_ready, full throughput under back-pressure).
REQ-021 SHALL, without ALU_ISSUE_SKID_EN, omit the skid register and SKID state, driving in_ready = !out_valid || out_ready combinationally; all other behaviour is unchanged.

Structure
REQ-022 SHALL place the opcode constants, aluOperation code constants and the issue-packet typedef in the shared package alu_pkg.
REQ-023 SHALL implement instruction decode in the combinational sub-module alu_op_decode; the state and registers live in alu_issue_stage.

Verification
REQ-024 SHALL cover these directed scenarios:
- ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1: next cycle operand_1=5, operand_2=7, aluOperation=0000, rd=3, reg_write=1.
- SRAI x4,x1,3 (funct7 0100000) then ADDI x5,x0,-1: aluOperation 0101 with operand_2=3, then 0000 with operand_2=0xFFFFFFFF.
- AUIPC x6,0x12345 at pc=0x100: operand_1=0x100, operand_2=0x12345000; LUI x7,0x12345: operand_1=0.
- out_ready=0 with 3 back-to-back instructions (SKID_EN): 2 accepted, in_ready=0, outputs stable; on out_ready=1 all 3 issue in order with no bubble.
- flush and in_valid asserted in the same cycle while in SKID: EMPTY next cycle, out_valid=0, the new instruction is not issued.
- opcode 0000011, or R-type funct7 0000001: illegal=1, reg_write=0; rst mid-stream gives out_valid=0 and in_ready=1 next cycle.
